synchronize_debounce: RTL and testbench

//  Parametrised multi-channel synchronizer for asynchronous level inputs: panel switches, jumpers, slow status lines.

---
 rtl/sync_pkg.sv | 30 +++
 rtl/debounce_channel.sv | 79 +++++++
 rtl/synchronize_debounce.sv | 58 +++++
 tb/tb_synchronize_debounce.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared constants and helpers for the synchronizer family.
package sync_pkg;

   // Shortest chain that still gives a metastability settling stage
   localparam int unsigned SYNC_MIN_STAGES = 2;

   // Width of one channel's rise/fall/changed tick
   localparam int unsigned SYNC_TICK_W = 1;

   // Ceiling log2; clog2(1) == 0
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      int unsigned limit;
      result = 0;
      limit  = 1;
      while (limit < value) begin
         limit  = limit << 1;
         result = result + 1;
      end
      return result;
   endfunction

   // Debounce counter width, never narrower than one bit
   function automatic int unsigned cnt_width(input int unsigned debounce);
      int unsigned w;
      w = clog2(debounce);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One bit of synchronize_debounce: sync chain, debounce counter, held level
// and optional rise/fall tick flops (built only with SYNC_EDGE_EN defined).
module debounce_channel
   import sync_pkg::*;
#(
   parameter int unsigned STAGES    = 2,
   parameter int unsigned DEBOUNCE  = 16,
   parameter logic        RESET_BIT = 1'b0
) (
   input  logic clock,
   input  logic reset_n,
   input  logic in,
   output logic out,
   output logic rise,
   output logic fall
`ifdef SYNC_EDGE_EN
   ,
   output logic tick_c
`endif
);

   localparam int unsigned CNT_W = cnt_width(DEBOUNCE);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

   // Reject illegal configurations at elaboration
   if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
      $error("debounce_channel: STAGES must be at least 2");
   end
   if (DEBOUNCE < 1) begin : g_bad_debounce
      $error("debounce_channel: DEBOUNCE must be at least 1");
   end

   logic [STAGES-1:0] sreg;
   logic [CNT_W-1:0]  cnt;
   logic              s;

   assign s = sreg[STAGES-1];

   // Sync chain is reset so it cannot be mapped onto a shift-register primitive
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sreg <= {STAGES{RESET_BIT}};
         out  <= RESET_BIT;
         cnt  <= '0;
      end else begin
         sreg <= {sreg[STAGES-2:0], in};
         if (s == out) begin
            cnt <= '0;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
         end else begin
            out <= s;
            cnt <= '0;
         end
      end
   end

`ifdef SYNC_EDGE_EN
   logic update_c;

   assign update_c = (s != out) && (cnt == CNT_MAX);
   assign tick_c   = update_c;

   // Ticks load on the same edge as out, so they mark its first new cycle
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= update_c & s;
         fall <= update_c & ~s;
      end
   end
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule

// File: rtl/synchronize_debounce.sv
// Multi-channel synchronizer + debouncer for asynchronous level inputs.
// Define SYNC_EDGE_EN to build the rise/fall/changed tick outputs;
// without it those outputs are constant 0 and out behaves identically.
module synchronize_debounce
   import sync_pkg::*;
#(
   parameter int unsigned       WIDTH       = 8,
   parameter int unsigned       STAGES      = 2,
   parameter int unsigned       DEBOUNCE    = 16,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);

`ifdef SYNC_EDGE_EN
   logic [WIDTH-1:0] tick_c;
`endif

   // One independent channel per input bit
   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      debounce_channel #(
         .STAGES    (STAGES),
         .DEBOUNCE  (DEBOUNCE),
         .RESET_BIT (RESET_VALUE[i])
      ) u_chan (
         .clock   (clock),
         .reset_n (reset_n),
         .in      (in[i]),
         .out     (out[i]),
         .rise    (rise[i]),
         .fall    (fall[i])
`ifdef SYNC_EDGE_EN
         ,
         .tick_c  (tick_c[i])
`endif
      );
   end

`ifdef SYNC_EDGE_EN
   // changed is registered alongside the channel tick flops
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         changed <= 1'b0;
      end else begin
         changed <= |tick_c;
      end
   end
`else
   assign changed = 1'b0;
`endif

endmodule

// File: tb/tb_synchronize_debounce.sv
// Directed bench for synchronize_debounce (WIDTH=4, STAGES=2, DEBOUNCE=4).
// Stimulus pushes the hand-computed post-edge state per cycle; a monitor
// pops and compares one entry after every rising edge.
module tb_synchronize_debounce;

   localparam int unsigned WIDTH = 4;

   typedef struct {
      logic [WIDTH-1:0] o;
      logic [WIDTH-1:0] r;
      logic [WIDTH-1:0] f;
      logic             c;
   } exp_t;

   logic             clock;
   logic             reset_n;
   logic [WIDTH-1:0] in;
   logic [WIDTH-1:0] out;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic             changed;

   exp_t exp_q[$];
   int   n_checks;
   int   n_errors;

   synchronize_debounce #(
      .WIDTH       (WIDTH),
      .STAGES      (2),
      .DEBOUNCE    (4),
      .RESET_VALUE (4'h0)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .in      (in),
      .out     (out),
      .rise    (rise),
      .fall    (fall),
      .changed (changed)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drive one cycle's inputs and queue the state expected after the next edge
   task automatic cyc(input logic rst, input logic [WIDTH-1:0] din,
                      input logic [WIDTH-1:0] eo, input logic [WIDTH-1:0] er,
                      input logic [WIDTH-1:0] ef);
      exp_t e;
      @(negedge clock);
      reset_n = rst;
      in      = din;
      e.o = eo;
`ifdef SYNC_EDGE_EN
      e.r = er;
      e.f = ef;
      e.c = |(er | ef);
`else
      e.r = '0;
      e.f = '0;
      e.c = 1'b0;
`endif
      exp_q.push_back(e);
   endtask

   // n cycles out of reset with no tick expected
   task automatic hold(input int n, input logic [WIDTH-1:0] din,
                       input logic [WIDTH-1:0] eo);
      for (int k = 0; k < n; k++) cyc(1'b1, din, eo, 4'h0, 4'h0);
   endtask

   // Monitor: compare one queued expectation per rising edge
   always begin
      exp_t e;
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         if (out !== e.o) begin
            n_errors++;
            $display("FAIL out t=%0t got=%h want=%h", $time, out, e.o);
         end
         n_checks++;
         if (rise !== e.r) begin
            n_errors++;
            $display("FAIL rise t=%0t got=%h want=%h", $time, rise, e.r);
         end
         n_checks++;
         if (fall !== e.f) begin
            n_errors++;
            $display("FAIL fall t=%0t got=%h want=%h", $time, fall, e.f);
         end
         n_checks++;
         if (changed !== e.c) begin
            n_errors++;
            $display("FAIL changed t=%0t got=%b want=%b", $time, changed, e.c);
         end
      end
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset_n  = 1'b0;
      in       = 4'hF;

      // 1. reset held 3 clocks with in=F, then out follows at edge 6
      for (int k = 0; k < 3; k++) cyc(1'b0, 4'hF, 4'h0, 4'h0, 4'h0);
      hold(5, 4'hF, 4'h0);
      cyc(1'b1, 4'hF, 4'hF, 4'hF, 4'h0);
      hold(3, 4'hF, 4'hF);

      // return all channels to 0 (fall on every bit)
      hold(5, 4'h0, 4'hF);
      cyc(1'b1, 4'h0, 4'h0, 4'h0, 4'hF);
      hold(2, 4'h0, 4'h0);

      // 2. three-clock glitch on in[1] is rejected
      hold(3, 4'h2, 4'h0);
      hold(6, 4'h0, 4'h0);

      // 3. bounce on in[2], then held high: out 6 clocks after last 0->1
      hold(2, 4'h4, 4'h0);
      hold(2, 4'h0, 4'h0);
      hold(2, 4'h4, 4'h0);
      hold(2, 4'h0, 4'h0);
      hold(5, 4'h4, 4'h0);
      cyc(1'b1, 4'h4, 4'h4, 4'h4, 4'h0);
      hold(2, 4'h4, 4'h4);

      // move to out=8 (bit 2 falls, bit 3 rises together)
      hold(5, 4'h8, 4'h4);
      cyc(1'b1, 4'h8, 4'h8, 4'h8, 4'h4);
      hold(2, 4'h8, 4'h8);

      // 4. simultaneous in[0] 0->1 and in[3] 1->0
      hold(5, 4'h1, 4'h8);
      cyc(1'b1, 4'h1, 4'h1, 4'h1, 4'h8);
      hold(2, 4'h1, 4'h1);

      // bring out back to 0
      hold(5, 4'h0, 4'h1);
      cyc(1'b1, 4'h0, 4'h0, 4'h0, 4'h1);
      hold(2, 4'h0, 4'h0);

      // 5. reset on the 4th clock of a count; full latency after release
      hold(3, 4'h1, 4'h0);
      cyc(1'b0, 4'h1, 4'h0, 4'h0, 4'h0);
      hold(5, 4'h1, 4'h0);
      cyc(1'b1, 4'h1, 4'h1, 4'h1, 4'h0);
      hold(2, 4'h1, 4'h1);

      // drain the scoreboard
      @(negedge clock);
      @(negedge clock);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain left=%0d want=0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
